alu_arbiter: RTL and testbench

- Shares the single 32-bit ALU between two requesters, for example the main datapath and a multi-cycle helper unit.
- Each requester has a valid/ready request channel and a valid/ready response channel.
- The block arbitrates round-robin and drives the ALU's A, B and ALUOp inputs from the winner.
- It captures C and Zero into a one-entry response register that returns to the granted requester.

---
 rtl/alu_arbiter.sv | 108 ++++++++++
 tb/tb_alu_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin (or fixed-priority) arbiter sharing one ALU between two requesters.
// The winner's operands drive the ALU; C/Zero are captured into a one-entry response register.
module alu_arbiter #(
    parameter int DATA_W = 32,
    parameter bit RR_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [1:0]        req0_op,
    output logic              resp0_valid,
    input  logic              resp0_ready,
    output logic [DATA_W-1:0] resp0_c,
    output logic              resp0_zero,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [1:0]        req1_op,
    output logic              resp1_valid,
    input  logic              resp1_ready,
    output logic [DATA_W-1:0] resp1_c,
    output logic              resp1_zero,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [1:0]        alu_op,
    input  logic [DATA_W-1:0] alu_c,
    input  logic              alu_zero,
    output logic              busy
);

    localparam logic [1:0] ALUOP_ADDU    = 2'b00;
    localparam logic [1:0] ALUOP_ILLEGAL = 2'b11;

    typedef enum logic {IDLE, HOLD} state_t;

    state_t            state, state_nxt;
    logic              owner, last_grant;
    logic [DATA_W-1:0] res_c;
    logic              res_zero;

    logic              accept, drain, grant, winner;
    logic [DATA_W-1:0] sel_a, sel_b;
    logic [1:0]        sel_op;

    // Arbitration: a draining HOLD reopens the accept window in the same cycle.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        drain  = (state == HOLD) && (owner ? resp1_ready : resp0_ready);
        accept = (state == IDLE) || drain;
        winner = 1'b0;
        if (req0_valid && req1_valid)
            winner = RR_EN ? ~last_grant : 1'b0;
        else if (req1_valid)
            winner = 1'b1;
        grant  = accept && (req0_valid || req1_valid);
        sel_a  = winner ? req1_a  : req0_a;
        sel_b  = winner ? req1_b  : req0_b;
        sel_op = winner ? req1_op : req0_op;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (grant)      state_nxt = HOLD;
        else if (drain) state_nxt = IDLE;
    end

    always_comb begin
        req0_ready  = grant && !winner;
        req1_ready  = grant &&  winner;
        alu_a       = grant ? sel_a : '0;
        alu_b       = grant ? sel_b : '0;
        alu_op      = (grant && sel_op != ALUOP_ILLEGAL) ? sel_op : ALUOP_ADDU;
        resp0_valid = (state == HOLD) && !owner;
        resp1_valid = (state == HOLD) &&  owner;
        busy        = (state == HOLD);
    end

    // Response register; last_grant resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_c      <= '0;
            res_zero   <= 1'b0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
        end else if (grant) begin
            res_c      <= (sel_op == ALUOP_ILLEGAL) ? '0 : alu_c;
            res_zero   <= alu_zero;
            owner      <= winner;
            last_grant <= winner;
        end
    end

    assign resp0_c    = res_c;
    assign resp0_zero = res_zero;
    assign resp1_c    = res_c;
    assign resp1_zero = res_zero;

endmodule

// File: tb/tb_alu_arbiter.sv
// Table-driven bench for alu_arbiter: a round-robin instance runs the vector table and
// async-reset sequence; a fixed-priority instance shares the request inputs.
module tb_alu_arbiter;

    localparam logic [1:0] A = 2'b00;  // ADDU
    localparam logic [1:0] S = 2'b01;  // SUBU
    localparam logic [1:0] O = 2'b10;  // OR
    localparam logic [1:0] X = 2'b11;  // illegal

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        req0_valid, req1_valid, resp0_ready, resp1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0]  req0_op, req1_op;

    logic        r_req0_ready, r_req1_ready, r_resp0_valid, r_resp1_valid, r_resp0_zero, r_resp1_zero, r_busy;
    logic [31:0] r_resp0_c, r_resp1_c, r_alu_a, r_alu_b, r_alu_c;
    logic [1:0]  r_alu_op;
    logic        r_alu_zero;

    logic        f_req0_ready, f_req1_ready, f_resp0_valid, f_resp1_valid, f_resp0_zero, f_resp1_zero, f_busy;
    logic [31:0] f_resp0_c, f_resp1_c, f_alu_a, f_alu_b, f_alu_c;
    logic [1:0]  f_alu_op;
    logic        f_alu_zero;

    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        case (op)
            2'b01:   return a - b;
            2'b10:   return a | b;
            default: return a + b;
        endcase
    endfunction

    assign r_alu_c    = alu_f(r_alu_a, r_alu_b, r_alu_op);
    assign r_alu_zero = (r_alu_a == r_alu_b);
    assign f_alu_c    = alu_f(f_alu_a, f_alu_b, f_alu_op);
    assign f_alu_zero = (f_alu_a == f_alu_b);

    alu_arbiter #(.DATA_W(32), .RR_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(r_req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .resp0_valid(r_resp0_valid), .resp0_ready(resp0_ready), .resp0_c(r_resp0_c), .resp0_zero(r_resp0_zero),
        .req1_valid(req1_valid), .req1_ready(r_req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .resp1_valid(r_resp1_valid), .resp1_ready(resp1_ready), .resp1_c(r_resp1_c), .resp1_zero(r_resp1_zero),
        .alu_a(r_alu_a), .alu_b(r_alu_b), .alu_op(r_alu_op), .alu_c(r_alu_c), .alu_zero(r_alu_zero),
        .busy(r_busy)
    );

    alu_arbiter #(.DATA_W(32), .RR_EN(1'b0)) dut_fp (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(f_req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .resp0_valid(f_resp0_valid), .resp0_ready(resp0_ready), .resp0_c(f_resp0_c), .resp0_zero(f_resp0_zero),
        .req1_valid(req1_valid), .req1_ready(f_req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .resp1_valid(f_resp1_valid), .resp1_ready(resp1_ready), .resp1_c(f_resp1_c), .resp1_zero(f_resp1_zero),
        .alu_a(f_alu_a), .alu_b(f_alu_b), .alu_op(f_alu_op), .alu_c(f_alu_c), .alu_zero(f_alu_zero),
        .busy(f_busy)
    );

    typedef struct {
        logic        v0;  logic [31:0] a0; logic [31:0] b0; logic [1:0] op0;
        logic        v1;  logic [31:0] a1; logic [31:0] b1; logic [1:0] op1;
        logic        rr0; logic        rr1;
        logic [1:0]  e_rdy;   // {req0_ready, req1_ready}
        logic [2:0]  e_vb;    // {resp0_valid, resp1_valid, busy}
        logic [31:0] e_c;     // owner's resp_c, 0 when no response pending
        logic        e_z;
        logic [1:0]  e_op;
        logic [31:0] e_a;
    } vec_t;

    function automatic vec_t mk(
        input logic v0, input logic [31:0] a0, input logic [31:0] b0, input logic [1:0] op0,
        input logic v1, input logic [31:0] a1, input logic [31:0] b1, input logic [1:0] op1,
        input logic rr0, input logic rr1, input logic [1:0] e_rdy, input logic [2:0] e_vb,
        input logic [31:0] e_c, input logic e_z, input logic [1:0] e_op, input logic [31:0] e_a);
        vec_t v;
        v.v0 = v0; v.a0 = a0; v.b0 = b0; v.op0 = op0;
        v.v1 = v1; v.a1 = a1; v.b1 = b1; v.op1 = op1;
        v.rr0 = rr0; v.rr1 = rr1; v.e_rdy = e_rdy; v.e_vb = e_vb;
        v.e_c = e_c; v.e_z = e_z; v.e_op = e_op; v.e_a = e_a;
        return v;
    endfunction

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        else
            n_pass++;
    endtask

    task automatic drive(input vec_t v);
        req0_valid = v.v0; req0_a = v.a0; req0_b = v.b0; req0_op = v.op0;
        req1_valid = v.v1; req1_a = v.a1; req1_b = v.b1; req1_op = v.op1;
        resp0_ready = v.rr0; resp1_ready = v.rr1;
    endtask

    function automatic logic [31:0] owner_c();
        return r_resp0_valid ? r_resp0_c : (r_resp1_valid ? r_resp1_c : 32'h0);
    endfunction

    function automatic logic owner_z();
        return r_resp0_valid ? r_resp0_zero : (r_resp1_valid ? r_resp1_zero : 1'b0);
    endfunction

    vec_t tbl[18];

    initial begin
        // Rows are applied one per cycle; expected resp fields reflect the previous rows' grants.
        tbl[0]  = mk(0, 0, 0, A,          0, 0, 0, A,             1, 1, 2'b00, 3'b000, 32'h0,  0, A, 32'h0);
        tbl[1]  = mk(1, 5, 3, A,          0, 0, 0, A,             1, 1, 2'b10, 3'b000, 32'h0,  0, A, 32'd5);
        tbl[2]  = mk(0, 0, 0, A,          0, 0, 0, A,             0, 1, 2'b00, 3'b101, 32'd8,  0, A, 32'h0);
        tbl[3]  = mk(0, 0, 0, A,          0, 0, 0, A,             1, 1, 2'b00, 3'b101, 32'd8,  0, A, 32'h0);
        tbl[4]  = mk(0, 0, 0, A,          0, 0, 0, A,             1, 1, 2'b00, 3'b000, 32'h0,  0, A, 32'h0);
        tbl[5]  = mk(1, 10, 4, S,         1, 32'hF0, 32'h0F, O,   1, 1, 2'b01, 3'b000, 32'h0,  0, O, 32'hF0);
        tbl[6]  = mk(1, 10, 4, S,         1, 32'hF0, 32'h0F, O,   1, 1, 2'b10, 3'b011, 32'hFF, 0, S, 32'd10);
        tbl[7]  = mk(1, 10, 4, S,         1, 32'hF0, 32'h0F, O,   1, 1, 2'b01, 3'b101, 32'd6,  0, O, 32'hF0);
        tbl[8]  = mk(1, 10, 4, S,         1, 32'hF0, 32'h0F, O,   1, 1, 2'b10, 3'b011, 32'hFF, 0, S, 32'd10);
        tbl[9]  = mk(0, 0, 0, A,          1, 32'hF0, 32'h0F, O,   1, 0, 2'b01, 3'b101, 32'd6,  0, O, 32'hF0);
        tbl[10] = mk(1, 9, 7, S,          0, 0, 0, A,             1, 0, 2'b00, 3'b011, 32'hFF, 0, A, 32'h0);
        tbl[11] = mk(1, 9, 7, S,          0, 0, 0, A,             1, 0, 2'b00, 3'b011, 32'hFF, 0, A, 32'h0);
        tbl[12] = mk(1, 9, 7, S,          0, 0, 0, A,             1, 0, 2'b00, 3'b011, 32'hFF, 0, A, 32'h0);
        tbl[13] = mk(1, 9, 7, S,          0, 0, 0, A,             1, 1, 2'b10, 3'b011, 32'hFF, 0, S, 32'd9);
        tbl[14] = mk(1, 32'h1234, 32'h1234, S, 0, 0, 0, A,        1, 1, 2'b10, 3'b101, 32'd2,  0, S, 32'h1234);
        tbl[15] = mk(1, 1, 2, X,          0, 0, 0, A,             1, 1, 2'b10, 3'b101, 32'h0,  1, A, 32'd1);
        tbl[16] = mk(0, 0, 0, A,          0, 0, 0, A,             1, 1, 2'b00, 3'b101, 32'h0,  0, A, 32'h0);
        tbl[17] = mk(0, 0, 0, A,          0, 0, 0, A,             1, 1, 2'b00, 3'b000, 32'h0,  0, A, 32'h0);

        drive(tbl[0]);
        #3;
        check("reset_resp_valid_busy", {29'h0, r_resp0_valid, r_resp1_valid, r_busy}, 32'h0);
        check("reset_resp_c", r_resp0_c | r_resp1_c, 32'h0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i]);
            @(negedge clk);
            check($sformatf("row%0d_ready", i), {30'h0, r_req0_ready, r_req1_ready}, {30'h0, tbl[i].e_rdy});
            check($sformatf("row%0d_valid_busy", i), {29'h0, r_resp0_valid, r_resp1_valid, r_busy}, {29'h0, tbl[i].e_vb});
            check($sformatf("row%0d_resp_c", i), owner_c(), tbl[i].e_c);
            check($sformatf("row%0d_resp_zero", i), {31'h0, owner_z()}, {31'h0, tbl[i].e_z});
            check($sformatf("row%0d_alu_op", i), {30'h0, r_alu_op}, {30'h0, tbl[i].e_op});
            check($sformatf("row%0d_alu_a", i), r_alu_a, tbl[i].e_a);
            @(posedge clk); #1;
        end

        // Async reset while HOLD with resp0 pending; last grant before reset was requester 0.
        drive(mk(1, 5, 3, A, 0, 0, 0, A, 1, 1, 2'b00, 3'b000, 0, 0, A, 0));
        @(negedge clk);
        check("pre_reset_grant0", {31'h0, r_req0_ready}, 32'h1);
        @(posedge clk); #1;
        drive(mk(0, 0, 0, A, 0, 0, 0, A, 0, 0, 2'b00, 3'b000, 0, 0, A, 0));
        @(negedge clk);
        check("pre_reset_hold_c", r_resp0_c, 32'd8);
        #2 rst = 1'b0;
        #1;
        check("async_reset_valid_busy", {29'h0, r_resp0_valid, r_resp1_valid, r_busy}, 32'h0);
        check("async_reset_c", r_resp0_c, 32'h0);
        @(posedge clk); #3;
        rst = 1'b1;

        // Both valid every cycle: RR instance alternates starting with 0, fixed priority starves requester 1.
        drive(mk(1, 10, 4, S, 1, 32'hF0, 32'h0F, O, 1, 1, 2'b00, 3'b000, 0, 0, A, 0));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("rr_tie%0d_ready", i), {30'h0, r_req0_ready, r_req1_ready},
                  (i % 2 == 0) ? 32'h2 : 32'h1);
            check($sformatf("fp_cyc%0d_ready", i), {30'h0, f_req0_ready, f_req1_ready}, 32'h2);
            if (i > 0) begin
                check($sformatf("fp_cyc%0d_resp_valid", i), {30'h0, f_resp0_valid, f_resp1_valid}, 32'h2);
                check($sformatf("fp_cyc%0d_resp_c", i), f_resp0_c, 32'd6);
            end
            @(posedge clk); #1;
        end

        drive(mk(0, 0, 0, A, 0, 0, 0, A, 1, 1, 2'b00, 3'b000, 0, 0, A, 0));
        @(posedge clk); @(posedge clk); #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
